// File: rtl/usb_evt_irq.sv
// usb_evt_irq
//   Interrupt controller and event queue for the USB core.
//   - NSRC interrupt sources, each either level (live) or edge (sticky, W1C).
//   - EVT_DEPTH x EVT_W event FIFO with an overflow flag.
//   - 4-word CSR window: 0 EVT (pop), 1 STAT (level/pending, W1C),
//     2 ENA (enable/mode/evt_ie), 3 CTRL (coalescing).
//   - Registered irq combining the enabled pending sources and the FIFO request.
// Optional feature macro: USB_EVT_IRQ_COALESCE_EN
//   Defined: CTRL holds THR[4:0] and TMO[15:8], and the FIFO request fires on a
//   level threshold or an age timeout. Undefined: CTRL reads 0 and the FIFO
//   request is simply "not empty".
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   src[NSRC]                  raw interrupt conditions
//   evt_data[EVT_W], evt_stb   event word and its push strobe
//   bus_cyc/we/addr/wdata      CSR request
//   bus_ack, bus_rdata         registered 1-cycle ack and read data
//   irq                        registered interrupt
module usb_evt_irq #(
    parameter int unsigned NSRC      = 6,
    parameter int unsigned EVT_W     = 12,
    parameter int unsigned EVT_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSRC-1:0]  src,
    input  logic [EVT_W-1:0] evt_data,
    input  logic             evt_stb,
    input  logic [1:0]       bus_addr,
    input  logic [15:0]      bus_wdata,
    output logic [15:0]      bus_rdata,
    input  logic             bus_we,
    input  logic             bus_cyc,
    output logic             bus_ack,
    output logic             irq
);

    localparam int unsigned PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [1:0] ADDR_EVT  = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_ENA  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    logic                 ack_q;
    logic [15:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;
    logic [NSRC-1:0]      src_q;
    logic [NSRC-1:0]      pend_q, pend_d;
    logic [NSRC-1:0]      en_q, en_d;
    logic [NSRC-1:0]      mode_q, mode_d;
    logic                 ie_q, ie_d;
    logic [EVT_W-1:0]     mem_q [EVT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ovf_q, ovf_d;

    logic                 access_c, rd_c, wr_c;
    logic                 empty_c, full_c, pop_c, push_c, fifo_req_c;
    logic [NSRC-1:0]      pending_c, w1c_c;
    logic [15:0]          ena_word_c;
    logic                 unused_wdata;

    // Bits of the write word that no register consumes.
    assign unused_wdata = ^bus_wdata;

    // Bus request decode, FIFO status and the visible pending vector.
    always_comb begin
        access_c   = bus_cyc & ~ack_q;
        rd_c       = access_c & ~bus_we;
        wr_c       = access_c & bus_we;
        empty_c    = (level_q == '0);
        full_c     = (level_q == LVL_W'(EVT_DEPTH));
        pop_c      = rd_c & (bus_addr == ADDR_EVT) & ~empty_c;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_c     = evt_stb & (~full_c | pop_c);
        pending_c  = (mode_q & pend_q) | (~mode_q & src);
        ena_word_c = '0;
        ena_word_c[NSRC-1:0]  = en_q;
        ena_word_c[NSRC+7:8]  = mode_q;
        ena_word_c[15]        = ie_q;
    end

`ifdef USB_EVT_IRQ_COALESCE_EN
    localparam int unsigned TMR_W = 18;

    logic [4:0]       thr_q, thr_d, thr_eff_c;
    logic [7:0]       tmo_q, tmo_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_c;

    // Threshold of 0 behaves as 1; the age timer counts cycles since non-empty.
    always_comb begin
        thr_eff_c  = (thr_q == 5'd0) ? 5'd1 : thr_q;
        timeout_c  = ~empty_c & (tmo_q != 8'd0) & (tmr_q >= {tmo_q, 10'd0});
        fifo_req_c = (6'(level_q) >= {1'b0, thr_eff_c}) | timeout_c;
        thr_d      = thr_q;
        tmo_d      = tmo_q;
        if (wr_c && (bus_addr == ADDR_CTRL)) begin
            thr_d = bus_wdata[4:0];
            tmo_d = bus_wdata[15:8];
        end
        if (empty_c) begin
            tmr_d = '0;
        end else if (tmr_q == '1) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Coalescing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '0;
            tmo_q <= '0;
            tmr_q <= '0;
        end else begin
            thr_q <= thr_d;
            tmo_q <= tmo_d;
            tmr_q <= tmr_d;
        end
    end
`else
    assign fifo_req_c = ~empty_c;
`endif

    // Next state: read mux, register writes, pending, FIFO pointers, irq.
    always_comb begin
        rdata_d  = '0;
        en_d     = en_q;
        mode_d   = mode_q;
        ie_d     = ie_q;
        w1c_c    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;

        if (rd_c) begin
            case (bus_addr)
                ADDR_EVT: begin
                    if (!empty_c) begin
                        rdata_d = {1'b1, ovf_q, 2'b00, 12'(mem_q[rd_ptr_q])};
                    end
                end
                ADDR_STAT: rdata_d = {3'b000, 5'(level_q), 8'(pending_c)};
                ADDR_ENA:  rdata_d = ena_word_c;
                default: begin
`ifdef USB_EVT_IRQ_COALESCE_EN
                    rdata_d = {tmo_q, 3'b000, thr_q};
`else
                    rdata_d = '0;
`endif
                end
            endcase
        end

        if (wr_c && (bus_addr == ADDR_STAT)) begin
            w1c_c = bus_wdata[NSRC-1:0];
        end
        if (wr_c && (bus_addr == ADDR_ENA)) begin
            en_d   = bus_wdata[NSRC-1:0];
            mode_d = bus_wdata[NSRC+7:8];
            ie_d   = bus_wdata[15];
        end

        // Sticky bits live only in edge mode; a new edge beats W1C; a mode change clears.
        pend_d = ((pend_q & ~w1c_c) | (src & ~src_q)) & mode_q & mode_d;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ovf_d    = 1'b0;
        end else if (evt_stb && !push_c) begin
            ovf_d    = 1'b1;
        end
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

        irq_d = (|(pending_c & en_q)) | (ie_q & fifo_req_c);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            src_q    <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            ie_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ack_q    <= access_c;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            src_q    <= src;
            pend_q   <= pend_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            ie_q     <= ie_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Event storage; contents are only observed when the level says valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= evt_data;
        end
    end

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

endmodule
